// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data memory model answering processor MEM-stage requests after a fixed,
// parameterised wait. One request is in flight at a time; requests are
// latched at accept, served in the RESP cycle, and acknowledged with a
// one-cycle MemReady pulse (MemError alongside it for rejected requests).
// Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned half
// and word accesses are rejected instead of being silently aligned.
module data_mem_responder #(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 12,
   parameter int WaitCycles = 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [31:0]          MemAddr,
   input  logic [1:0]           MemRead,
   input  logic [1:0]           MemWrite,
   input  logic [DataWidth-1:0] DataMemIn,
   output logic [DataWidth-1:0] DataMemOut,
   output logic                 MemReady,
   output logic                 MemBusy,
   output logic                 MemError
);

   localparam int IdxWidth = AddrWidth - 2;
   localparam int Words    = 2 ** IdxWidth;

   localparam logic [1:0] SizeNone = 2'b00;
   localparam logic [1:0] SizeByte = 2'b01;
   localparam logic [1:0] SizeHalf = 2'b10;
   localparam logic [1:0] SizeWord = 2'b11;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q;
   logic [31:0]          addr_q;
   logic [1:0]           rd_size_q, wr_size_q;
   logic [DataWidth-1:0] wdata_q;
   logic [DataWidth-1:0] rdata_q;
   logic [DataWidth-1:0] mem [Words];

   logic                 req;
   logic                 reject;
   logic                 do_write;
   logic [IdxWidth-1:0]  idx;
   logic [1:0]           lane;
   logic [4:0]           byte_off, half_off;
   logic [DataWidth-1:0] word;
   logic [7:0]           byte_v;
   logic [15:0]          half_v;
   logic [DataWidth-1:0] rd_value;

   assign req      = (MemRead != SizeNone) || (MemWrite != SizeNone);
   assign idx      = addr_q[AddrWidth-1:2];
   assign lane     = addr_q[1:0];
   assign byte_off = {lane, 3'b000};
   // A half access selects its lanes from address bit 1 only; bit 0 never moves it.
   assign half_off = {lane[1], 4'b0000};
   assign word     = mem[idx];
   assign byte_v   = word[byte_off +: 8];
   assign half_v   = word[half_off +: 16];
   assign do_write = (state_q == RESP) && !reject && (wr_size_q != SizeNone);

   // State register: reset returns to IDLE at once, aborting any held request.
   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: only IDLE accepts; WAIT counts down to RESP; RESP lasts one cycle.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = (WaitCycles > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the request at accept and run the wait counter while in WAIT.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         rd_size_q <= SizeNone;
         wr_size_q <= SizeNone;
         wdata_q   <= '0;
      end else if ((state_q == IDLE) && req) begin
         cnt_q     <= (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;
         addr_q    <= MemAddr;
         rd_size_q <= MemRead;
         wr_size_q <= MemWrite;
         wdata_q   <= DataMemIn;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Decide whether the held request is rejected (mixed read/write, out of range, misaligned).
   always_comb begin
      reject = (rd_size_q != SizeNone) && (wr_size_q != SizeNone);
      if ((addr_q >> AddrWidth) != 32'd0) begin
         reject = 1'b1;
      end
`ifdef DMEM_ALIGN_CHECK_EN
      if (((rd_size_q == SizeHalf) || (wr_size_q == SizeHalf)) && addr_q[0]) begin
         reject = 1'b1;
      end
      if (((rd_size_q == SizeWord) || (wr_size_q == SizeWord)) && (addr_q[1:0] != 2'b00)) begin
         reject = 1'b1;
      end
`else
      // Misaligned accesses are served on the aligned lanes instead of being rejected.
`endif
   end

   // Extract and sign-extend the addressed lanes; rejected requests read as zero.
   always_comb begin
      rd_value = '0;
      case (rd_size_q)
         SizeByte: rd_value = {{(DataWidth-8){byte_v[7]}}, byte_v};
         SizeHalf: rd_value = {{(DataWidth-16){half_v[15]}}, half_v};
         SizeWord: rd_value = word;
         default:  rd_value = '0;
      endcase
      if (reject) begin
         rd_value = '0;
      end
   end

   // Commit writes at the end of the response cycle, touching only the addressed lanes.
   // NOTE: storage has no reset: its contents must survive Rst, and a reset would block RAM mapping.
   always_ff @(posedge Clk) begin
      if (do_write) begin
         case (wr_size_q)
            SizeByte: mem[idx][byte_off +: 8]  <= wdata_q[7:0];
            SizeHalf: mem[idx][half_off +: 16] <= wdata_q[15:0];
            SizeWord: mem[idx]                 <= wdata_q;
            default:  mem[idx]                 <= mem[idx];
         endcase
      end
   end

   // Hold the last response's read data so DataMemOut stays stable between responses.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdata_q <= '0;
      end else if (state_q == RESP) begin
         rdata_q <= DataMemOut;
      end
   end

   // Outputs: handshake flags decode the state; read data is live during RESP, held otherwise.
   always_comb begin
      MemReady   = (state_q == RESP);
      MemBusy    = (state_q != IDLE);
      MemError   = (state_q == RESP) && reject;
      DataMemOut = rdata_q;
      if ((state_q == RESP) && (reject || (rd_size_q != SizeNone))) begin
         DataMemOut = rd_value;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus random traffic.
// A driver issues requests and queues the expected response computed from a
// byte-array memory model; a monitor pops and compares on every MemReady.
module tb_data_mem_responder;

   localparam int W  = 1;
   localparam int AW = 12;
   localparam longint ADDR_LIMIT = (longint'(1) << AW) - 1;

   typedef struct {
      int          id;
      bit          chk_data;
      logic [31:0] data;
      bit          err;
      int          ready_edge;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] MemAddr;
   logic [1:0]  MemRead;
   logic [1:0]  MemWrite;
   logic [31:0] DataMemIn;
   logic [31:0] DataMemOut;
   logic        MemReady;
   logic        MemBusy;
   logic        MemError;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   next_id = 0;
   exp_t exp_q[$];
   logic [7:0] mem_m [0:(1<<AW)-1];

   data_mem_responder #(
      .DataWidth (32),
      .AddrWidth (AW),
      .WaitCycles(W)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .MemAddr   (MemAddr),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .DataMemIn (DataMemIn),
      .DataMemOut(DataMemOut),
      .MemReady  (MemReady),
      .MemBusy   (MemBusy),
      .MemError  (MemError)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed little-endian memory, sizes in bytes.
   function automatic void model_access(input logic [1:0] rd, input logic [1:0] wr,
                                        input logic [31:0] addr, input logic [31:0] data,
                                        output bit err, output logic [31:0] rv);
      logic [1:0]  sz;
      int          nbytes;
      longint      base;
      longint      v;
      sz     = (rd != 2'b00) ? rd : wr;
      nbytes = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
      err    = ((rd != 2'b00) && (wr != 2'b00)) || (longint'(addr) > ADDR_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
      if ((addr % nbytes) != 0) err = 1'b1;
`endif
      rv = 32'd0;
      if (err) return;
      base = longint'(addr) - longint'(addr % nbytes);
      if (wr != 2'b00) begin
         for (int b = 0; b < nbytes; b++) mem_m[base + b] = data[8*b +: 8];
      end else begin
         v = 0;
         for (int b = 0; b < nbytes; b++) v = v + (longint'(mem_m[base + b]) << (8*b));
         if (nbytes < 4 && v >= (longint'(1) << (8*nbytes - 1))) v = v - (longint'(1) << (8*nbytes));
         rv = 32'(v);
      end
   endfunction

   // Issue one request, queue its expectation, and hold it until MemReady.
   // junk: change the inputs while busy (must be ignored).
   // abort: pulse Rst right after accept (no response, no commit).
   task automatic do_req(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit junk, input bit abort);
      exp_t        e;
      bit          err;
      logic [31:0] rv;
      bit          got;
      @(negedge Clk);
      MemRead   = rd;
      MemWrite  = wr;
      MemAddr   = addr;
      DataMemIn = data;
      if (abort) begin
         @(posedge Clk);
         #2;
         Rst = 1'b1;
         #1;
         check("abort_DataMemOut", DataMemOut, 32'd0);
         check("abort_MemReady", 32'(MemReady), 32'd0);
         check("abort_MemBusy", 32'(MemBusy), 32'd0);
         check("abort_MemError", 32'(MemError), 32'd0);
         @(negedge Clk);
         Rst      = 1'b0;
         MemRead  = 2'b00;
         MemWrite = 2'b00;
         return;
      end
      model_access(rd, wr, addr, data, err, rv);
      e.id         = next_id++;
      e.chk_data   = err || (rd != 2'b00);
      e.data       = rv;
      e.err        = err;
      e.ready_edge = cyc + 1 + W + 1;
      exp_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         @(negedge Clk);
         if (MemReady) begin
            got = 1'b1;
            break;
         end
         if (junk) begin
            MemRead   = 2'b00;
            MemWrite  = 2'b11;
            MemAddr   = 32'h0000_0018;
            DataMemIn = 32'hBAD0_BAD0;
         end
      end
      MemRead  = 2'b00;
      MemWrite = 2'b00;
      if (!got) check("response_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: every MemReady must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (!Rst && MemReady) begin
         if (exp_q.size() == 0) begin
            check("unexpected_MemReady", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("latency#%0d", e.id), 32'(cyc + 1), 32'(e.ready_edge));
            check($sformatf("MemError#%0d", e.id), 32'(MemError), 32'(e.err));
            check($sformatf("MemBusy#%0d", e.id), 32'(MemBusy), 32'd1);
            if (e.chk_data) check($sformatf("DataMemOut#%0d", e.id), DataMemOut, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  rd, wr, sz;
      logic [31:0] addr;
      int          kind;
      Rst       = 1'b1;
      MemAddr   = 32'd0;
      MemRead   = 2'b00;
      MemWrite  = 2'b00;
      DataMemIn = 32'd0;
      repeat (3) @(negedge Clk);
      check("reset_DataMemOut", DataMemOut, 32'd0);
      check("reset_MemReady", 32'(MemReady), 32'd0);
      check("reset_MemBusy", 32'(MemBusy), 32'd0);
      check("reset_MemError", 32'(MemError), 32'd0);
      Rst = 1'b0;

      // Give the working window known contents.
      for (int a = 0; a < 64; a += 4) do_req(2'b00, 2'b11, 32'(a), $urandom, 1'b0, 1'b0);

      // Word write / read-back.
      do_req(2'b00, 2'b11, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0);
      do_req(2'b11, 2'b00, 32'h010, 32'h0, 1'b0, 1'b0);
      // Byte write into lane 3, signed byte read, word read.
      do_req(2'b00, 2'b01, 32'h013, 32'h0000_0080, 1'b0, 1'b0);
      do_req(2'b01, 2'b00, 32'h013, 32'h0, 1'b0, 1'b0);
      do_req(2'b11, 2'b00, 32'h010, 32'h0, 1'b0, 1'b0);
      // Misaligned half read (rejected or aligned depending on build).
      do_req(2'b10, 2'b00, 32'h011, 32'h0, 1'b0, 1'b0);
      // Mixed read+write and out-of-range read are rejected; storage untouched.
      do_req(2'b11, 2'b11, 32'h010, 32'h1111_1111, 1'b0, 1'b0);
      do_req(2'b11, 2'b00, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
      do_req(2'b00, 2'b11, 32'h8000_0010, 32'h2222_2222, 1'b0, 1'b0);
      do_req(2'b11, 2'b00, 32'h010, 32'h0, 1'b0, 1'b0);
      // Inputs changed while busy are ignored.
      do_req(2'b11, 2'b00, 32'h014, 32'h0, 1'b1, 1'b0);
      do_req(2'b11, 2'b00, 32'h018, 32'h0, 1'b0, 1'b0);
      // Reset mid-request aborts a pending write.
      do_req(2'b00, 2'b11, 32'h020, 32'hCAFE_F00D, 1'b0, 1'b0);
      do_req(2'b11, 2'b00, 32'h020, 32'h0, 1'b0, 1'b0);
      do_req(2'b00, 2'b11, 32'h020, 32'h1234_5678, 1'b0, 1'b1);
      do_req(2'b11, 2'b00, 32'h020, 32'h0, 1'b0, 1'b0);

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 19);
         sz   = 2'($urandom_range(1, 3));
         addr = 32'($urandom_range(0, 63));
         rd   = 2'b00;
         wr   = 2'b00;
         if (kind < 9) rd = sz;
         else if (kind < 18) wr = sz;
         else begin
            rd = sz;
            wr = 2'($urandom_range(1, 3));
         end
         if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(AW, 31));
         do_req(rd, wr, addr, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
      end

      repeat (W + 5) @(negedge Clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
